// File: rtl/mul_issue_sched.sv
// mul_issue_sched: sequences the shared multi-cycle multiplier and raises front-end stalls on its hazards
// Ports: clk, rst_n (async, active-low); issue_valid_i/mul_start_i/wr_regfile_i/rs_i/rt_i/rd_i decoded
// instruction; flush_i aborts a pending MUL; mul_start_o start pulse; mul_busy_o MUL outstanding;
// stall_o combinational front-end hold; wb_valid_o/wb_rd_o one-cycle product writeback.
// Optional MUL_ISSUE_SCHED_PERF_EN adds perf_stall_cnt_o, a saturating count of stalled cycles.
module mul_issue_sched #(
    parameter int MUL_LATENCY = 4,
    parameter int CNT_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       issue_valid_i,
    input  logic       mul_start_i,
    input  logic       wr_regfile_i,
    input  logic [4:0] rs_i,
    input  logic [4:0] rt_i,
    input  logic [4:0] rd_i,
    input  logic       flush_i,
    output logic       mul_start_o,
    output logic       mul_busy_o,
    output logic       stall_o,
    output logic       wb_valid_o,
`ifdef MUL_ISSUE_SCHED_PERF_EN
    output logic [15:0] perf_stall_cnt_o,
`endif
    output logic [4:0] wb_rd_o
);
    typedef enum logic [1:0] {IDLE, START, COUNT, DONE} state_t;
    state_t state;
    logic [CNT_W-1:0] cnt;
    logic [4:0] pend_rd;
    logic wb_q;
    logic pend_nz;
    logic accept;
    always_comb begin
        pend_nz = pend_rd != 5'd0;
        stall_o = state != IDLE && issue_valid_i && (mul_start_i ||
                  (pend_nz && (rs_i == pend_rd || rt_i == pend_rd || (wr_regfile_i && rd_i == pend_rd))));
        accept  = issue_valid_i && mul_start_i && wr_regfile_i && !stall_o && !flush_i;
    end
    // a flush landing in DONE must kill that same cycle's writeback
    assign wb_valid_o = wb_q && !flush_i;
    assign wb_rd_o = pend_rd;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            pend_rd     <= '0;
            mul_start_o <= 1'b0;
            mul_busy_o  <= 1'b0;
            wb_q        <= 1'b0;
        end else begin
            mul_start_o <= 1'b0;
            wb_q        <= 1'b0;
            if (flush_i) begin
                state      <= IDLE;
                mul_busy_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (accept) begin
                        pend_rd     <= rd_i;
                        state       <= START;
                        mul_start_o <= 1'b1;
                        mul_busy_o  <= 1'b1;
                    end
                    START: begin
                        cnt   <= CNT_W'(MUL_LATENCY - 1);
                        state <= COUNT;
                    end
                    COUNT: begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state <= DONE;
                            wb_q  <= pend_nz;
                        end
                    end
                    DONE: begin
                        state      <= IDLE;
                        mul_busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end
`ifdef MUL_ISSUE_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perf_stall_cnt_o <= '0;
        else if (flush_i) perf_stall_cnt_o <= '0;
        else if (stall_o && perf_stall_cnt_o != 16'hFFFF) perf_stall_cnt_o <= perf_stall_cnt_o + 16'd1;
    end
`endif
endmodule

// File: tb/tb_mul_issue_sched.sv
// tb_mul_issue_sched: randomized and directed bench for mul_issue_sched against an age-based reference model
module tb_mul_issue_sched;
    localparam int L = 4;
    logic clk = 0, rst_n = 0, iv = 0, ms = 0, wr = 0, fl = 0;
    logic [4:0] rs = 0, rt = 0, rd = 0;
    logic mul_start_o, mul_busy_o, stall_o, wb_valid_o;
    logic [4:0] wb_rd_o;
`ifdef MUL_ISSUE_SCHED_PERF_EN
    logic [15:0] perf_stall_cnt_o;
`endif
    int checks = 0, errors = 0;

    mul_issue_sched #(.MUL_LATENCY(L), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .issue_valid_i(iv), .mul_start_i(ms), .wr_regfile_i(wr),
        .rs_i(rs), .rt_i(rt), .rd_i(rd), .flush_i(fl),
        .mul_start_o(mul_start_o), .mul_busy_o(mul_busy_o), .stall_o(stall_o), .wb_valid_o(wb_valid_o),
`ifdef MUL_ISSUE_SCHED_PERF_EN
        .perf_stall_cnt_o(perf_stall_cnt_o),
`endif
        .wb_rd_o(wb_rd_o));

    always #5 clk = ~clk;

    // Reference model: one outstanding MUL described by its accept cycle and destination.
    // Age 1 is the start pulse, age L+1 is the writeback cycle.
    int cyc = 0, acc_cyc = 0, age, m_perf = 0;
    bit inflight = 0;
    logic [4:0] m_rd = 0;
    logic e_busy, e_start, e_done, e_wb, e_stall, e_acc;
    always_comb begin
        age     = cyc - acc_cyc;
        e_busy  = inflight;
        e_start = inflight && age == 1;
        e_done  = inflight && age == L + 1;
        e_wb    = e_done && m_rd != 0 && !fl;
        e_stall = inflight && iv && (ms || (m_rd != 0 && (rs == m_rd || rt == m_rd || (wr && rd == m_rd))));
        e_acc   = iv && ms && wr && !e_stall && !fl;
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 0;
            m_perf   <= 0;
        end else begin
            cyc <= cyc + 1;
            if (fl || e_done) inflight <= 0;
            else if (e_acc) begin
                inflight <= 1;
                acc_cyc  <= cyc;
                m_rd     <= rd;
            end
            m_perf <= fl ? 0 : (e_stall && m_perf < 65535) ? m_perf + 1 : m_perf;
        end
    end

    task automatic drive(input logic v, m, w, input logic [4:0] a, b, d, input logic f);
        @(negedge clk);
        iv = v; ms = m; wr = w; rs = a; rt = b; rd = d; fl = f;
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3 * L + 10 && e_busy; i++) drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (mul_busy_o !== 1'b0 || e_busy) begin
            errors++; $display("FAIL idle_wait busy=%b expected 0", mul_busy_o);
        end
    endtask

    task automatic test_reset();
        iv = 1; ms = 1; wr = 1; rd = 5;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (mul_start_o !== 1'b0) begin errors++; $display("FAIL reset_start got=%b exp=0", mul_start_o); end
        checks++; if (mul_busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", mul_busy_o); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
        checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL reset_wb got=%b exp=0", wb_valid_o); end
        checks++; if (wb_rd_o !== 5'd0) begin errors++; $display("FAIL reset_wb_rd got=%0d exp=0", wb_rd_o); end
        @(negedge clk);
        rst_n = 1; iv = 0; ms = 0; wr = 0; rd = 0;
    endtask

    task automatic test_latency();
        int wb_at = -1;
        wait_idle();
        drive(1, 1, 1, 5'd1, 5'd2, 5'd5, 0);
        for (int i = 0; i <= L + 2; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            checks++; if (mul_start_o !== e_start) begin errors++; $display("FAIL lat_start[%0d] got=%b exp=%b", i, mul_start_o, e_start); end
            checks++; if (mul_busy_o !== e_busy) begin errors++; $display("FAIL lat_busy[%0d] got=%b exp=%b", i, mul_busy_o, e_busy); end
            checks++; if (wb_valid_o !== e_wb) begin errors++; $display("FAIL lat_wb[%0d] got=%b exp=%b", i, wb_valid_o, e_wb); end
            if (wb_valid_o === 1'b1) begin
                if (wb_at < 0) wb_at = i;
                checks++; if (wb_rd_o !== 5'd5) begin errors++; $display("FAIL lat_wb_rd got=%0d exp=5", wb_rd_o); end
            end
        end
        checks++; if (wb_at != L) begin errors++; $display("FAIL lat_wb_cycle got=%0d exp=%0d", wb_at, L); end
    endtask

    task automatic test_raw();
        int n = 0;
        wait_idle();
        drive(1, 1, 1, 5'd1, 5'd2, 5'd5, 0);
        for (int i = 0; i < 2 * L + 4; i++) begin
            drive(1, 0, 1, 5'd5, 5'd2, 5'd7, 0);
            checks++; if (stall_o !== e_stall) begin errors++; $display("FAIL raw_stall[%0d] got=%b exp=%b", i, stall_o, e_stall); end
            if (stall_o === 1'b1) n++;
            if (!e_stall) break;
        end
        checks++; if (n != L + 1) begin errors++; $display("FAIL raw_stall_cycles got=%0d exp=%0d", n, L + 1); end
        wait_idle();
        drive(1, 1, 1, 5'd1, 5'd2, 5'd5, 0);
        for (int i = 0; i <= L; i++) begin
            drive(1, 0, 1, 5'd3, 5'd4, 5'd8, 0);
            checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL indep_stall[%0d] got=%b exp=0", i, stall_o); end
        end
    endtask

    task automatic test_back_to_back();
        bit second = 0;
        int p[$];
        wait_idle();
        drive(1, 1, 1, 5'd1, 5'd2, 5'd3, 0);
        for (int k = 0; k < 2 * L + 8; k++) begin
            if (!second) drive(1, 1, 1, 5'd1, 5'd2, 5'd4, 0);
            else drive(0, 0, 0, 0, 0, 0, 0);
            checks++; if (stall_o !== e_stall) begin errors++; $display("FAIL b2b_stall[%0d] got=%b exp=%b", k, stall_o, e_stall); end
            checks++; if (mul_start_o !== e_start) begin errors++; $display("FAIL b2b_start[%0d] got=%b exp=%b", k, mul_start_o, e_start); end
            checks++; if (wb_valid_o !== e_wb) begin errors++; $display("FAIL b2b_wb[%0d] got=%b exp=%b", k, wb_valid_o, e_wb); end
            if (mul_start_o === 1'b1) p.push_back(k);
            if (!second && e_acc) second = 1;
        end
        checks++;
        if (p.size() != 2) begin errors++; $display("FAIL b2b_pulses got=%0d exp=2", p.size()); end
        else if (p[1] - p[0] != L + 2) begin errors++; $display("FAIL b2b_spacing got=%0d exp=%0d", p[1] - p[0], L + 2); end
    endtask

    task automatic test_rd0();
        wait_idle();
        drive(1, 1, 1, 5'd1, 5'd2, 5'd0, 0);
        for (int i = 0; i <= L + 1; i++) begin
            drive(1, 0, 1, 5'd0, 5'd0, 5'd0, 0);
            checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rd0_stall[%0d] got=%b exp=0", i, stall_o); end
            checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL rd0_wb[%0d] got=%b exp=0", i, wb_valid_o); end
            checks++; if (mul_busy_o !== e_busy) begin errors++; $display("FAIL rd0_busy[%0d] got=%b exp=%b", i, mul_busy_o, e_busy); end
        end
    endtask

    task automatic test_flush();
        int tg[2] = '{2, L + 1};
        wait_idle();
        drive(1, 1, 1, 5'd1, 5'd2, 5'd6, 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++; if (mul_busy_o !== 1'b0) begin errors++; $display("FAIL flush_issue_busy got=%b exp=0", mul_busy_o); end
        foreach (tg[t]) begin
            wait_idle();
            drive(1, 1, 1, 5'd1, 5'd2, 5'd6, 0);
            for (int j = 1; j < tg[t]; j++) drive(0, 0, 0, 0, 0, 0, 0);
            drive(0, 0, 0, 0, 0, 0, 1);
            checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL flush%0d_wb got=%b exp=0", t, wb_valid_o); end
            checks++; if (mul_busy_o !== 1'b1) begin errors++; $display("FAIL flush%0d_busy_before got=%b exp=1", t, mul_busy_o); end
            drive(1, 1, 1, 5'd1, 5'd2, 5'd9, 0);
            checks++; if (mul_busy_o !== 1'b0) begin errors++; $display("FAIL flush%0d_idle got=%b exp=0", t, mul_busy_o); end
            checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL flush%0d_stall got=%b exp=0", t, stall_o); end
            drive(0, 0, 0, 0, 0, 0, 0);
            checks++; if (mul_start_o !== 1'b1) begin errors++; $display("FAIL flush%0d_restart got=%b exp=1", t, mul_start_o); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  $urandom_range(0, 39) == 0);
            checks++; if (stall_o !== e_stall) begin errors++; $display("FAIL rnd_stall[%0d] got=%b exp=%b", i, stall_o, e_stall); end
            checks++; if (mul_start_o !== e_start) begin errors++; $display("FAIL rnd_start[%0d] got=%b exp=%b", i, mul_start_o, e_start); end
            checks++; if (mul_busy_o !== e_busy) begin errors++; $display("FAIL rnd_busy[%0d] got=%b exp=%b", i, mul_busy_o, e_busy); end
            checks++; if (wb_valid_o !== e_wb) begin errors++; $display("FAIL rnd_wb[%0d] got=%b exp=%b", i, wb_valid_o, e_wb); end
            if (e_wb) begin
                checks++; if (wb_rd_o !== m_rd) begin errors++; $display("FAIL rnd_wb_rd[%0d] got=%0d exp=%0d", i, wb_rd_o, m_rd); end
            end
        end
        fl = 0;
    endtask

    task automatic test_async_reset();
        wait_idle();
`ifdef MUL_ISSUE_SCHED_PERF_EN
        checks++; if (perf_stall_cnt_o !== m_perf[15:0]) begin errors++; $display("FAIL perf_cnt got=%0d exp=%0d", perf_stall_cnt_o, m_perf); end
`endif
        drive(1, 1, 1, 5'd1, 5'd2, 5'd5, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        iv = 1; ms = 1; wr = 1; rd = 5;
        #1;
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL arst_pre_stall got=%b exp=1", stall_o); end
        rst_n = 0;
        #1;
        checks++; if (mul_busy_o !== 1'b0) begin errors++; $display("FAIL arst_busy got=%b exp=0", mul_busy_o); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL arst_stall got=%b exp=0", stall_o); end
        checks++; if (mul_start_o !== 1'b0) begin errors++; $display("FAIL arst_start got=%b exp=0", mul_start_o); end
        checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL arst_wb got=%b exp=0", wb_valid_o); end
        checks++; if (wb_rd_o !== 5'd0) begin errors++; $display("FAIL arst_wb_rd got=%0d exp=0", wb_rd_o); end
`ifdef MUL_ISSUE_SCHED_PERF_EN
        checks++; if (perf_stall_cnt_o !== 16'd0) begin errors++; $display("FAIL arst_perf got=%0d exp=0", perf_stall_cnt_o); end
`endif
        @(negedge clk);
        rst_n = 1; iv = 0; ms = 0; wr = 0; rd = 0;
        for (int i = 0; i < L + 2; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            checks++; if (wb_valid_o !== 1'b0 || mul_busy_o !== 1'b0) begin
                errors++; $display("FAIL arst_after[%0d] wb=%b busy=%b exp 0/0", i, wb_valid_o, mul_busy_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_raw();
        test_back_to_back();
        test_rd0();
        test_flush();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
